// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT butterfly scheduler and its butterfly wrappers.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } fft_sched_state_t;

  localparam int BFLY_LATENCY_DEFAULT = 4;

  function automatic int stage_width(input int log2n);
    return $clog2(log2n + 1);
  endfunction

  function automatic int addr_width(input int n_points);
    return $clog2(n_points);
  endfunction

  function automatic int tw_width(input int log2n);
    return log2n - 1;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address and twiddle-index generator for in-place radix-2 DIT.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = 3,
  localparam int SW = stage_width(LOG2N),
  localparam int TW = tw_width(LOG2N)
) (
  input  logic [SW-1:0]    stage,
  input  logic [TW-1:0]    k,
  output logic [LOG2N-1:0] addr0,
  output logic [LOG2N-1:0] addr1,
  output logic [TW-1:0]    tw_idx
);

  logic [TW-1:0]    pos_mask;
  logic [TW-1:0]    pos;
  logic [LOG2N-1:0] span;
  logic [SW-1:0]    tw_shift;

  // Group index times 2*span is just the upper bits of k shifted left once.
  always_comb begin
    pos_mask = ~({TW{1'b1}} << stage);
    pos      = k & pos_mask;
    span     = LOG2N'(1) << stage;
    addr0    = {k & ~pos_mask, 1'b0} | {1'b0, pos};
    addr1    = addr0 + span;
    tw_shift = SW'(TW) - stage;
    tw_idx   = pos << tw_shift;
  end

endmodule

// File: rtl/fft_bfly_scheduler.sv
// Stage/pair sequencer for an in-place radix-2 FFT through one pipelined butterfly,
// with a fixed-latency write-address delay line.
module fft_bfly_scheduler
  import fft_pkg::*;
#(
  parameter int N_POINTS     = 8,
  parameter int LOG2N        = $clog2(N_POINTS),
  parameter int BFLY_LATENCY = BFLY_LATENCY_DEFAULT,
  parameter int MEM_LATENCY  = 1,
  localparam int SW = stage_width(LOG2N),
  localparam int TW = tw_width(LOG2N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rd_en,
  output logic             rd_bank,
  output logic [LOG2N-1:0] rd_addr0,
  output logic [LOG2N-1:0] rd_addr1,
  output logic [TW-1:0]    tw_idx,
  output logic             wr_en,
  output logic             wr_bank,
  output logic [LOG2N-1:0] wr_addr0,
  output logic [LOG2N-1:0] wr_addr1,
  output logic [SW-1:0]    stage,
  output logic             result_bank
);

  localparam int L   = MEM_LATENCY + BFLY_LATENCY;
  localparam int DCW = (L > 1) ? $clog2(L) : 1;
  localparam int DLW = 2 * LOG2N + 2;
  localparam logic [LOG2N-1:0] HALF        = LOG2N'(N_POINTS / 2);
  localparam logic [SW-1:0]    LAST_STAGE  = SW'(LOG2N - 1);
  localparam logic             RESULT_BANK = 1'(LOG2N % 2);

  fft_sched_state_t state_reg;
  logic [SW-1:0]    stage_reg;
  logic [LOG2N-1:0] k_reg;
  logic [DCW-1:0]   drain_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             rd_en_reg;
  logic [LOG2N-1:0] rd_addr0_reg;
  logic [LOG2N-1:0] rd_addr1_reg;
  logic [TW-1:0]    tw_reg;

  logic [SW-1:0]    gen_stage;
  logic [LOG2N-1:0] gen_addr0;
  logic [LOG2N-1:0] gen_addr1;
  logic [TW-1:0]    gen_tw;
  logic             flush;

  assign flush = rst | abort;

  // k_reg always holds the next pair to issue; while draining, look ahead to the next stage.
  assign gen_stage = (state_reg == ST_DRAIN) ? stage_reg + SW'(1) : stage_reg;

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .stage (gen_stage),
    .k     (k_reg[TW-1:0]),
    .addr0 (gen_addr0),
    .addr1 (gen_addr1),
    .tw_idx(gen_tw)
  );

  always_ff @(posedge clk) begin
    if (flush) begin
      state_reg    <= ST_IDLE;
      stage_reg    <= '0;
      k_reg        <= '0;
      drain_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      rd_en_reg    <= 1'b0;
      rd_addr0_reg <= '0;
      rd_addr1_reg <= '0;
      tw_reg       <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg    <= ST_ISSUE;
            busy_reg     <= 1'b1;
            rd_en_reg    <= 1'b1;
            rd_addr0_reg <= gen_addr0;
            rd_addr1_reg <= gen_addr1;
            tw_reg       <= gen_tw;
            k_reg        <= k_reg + LOG2N'(1);
          end
        end
        ST_ISSUE: begin
          if (k_reg == HALF) begin
            state_reg    <= ST_DRAIN;
            rd_en_reg    <= 1'b0;
            rd_addr0_reg <= '0;
            rd_addr1_reg <= '0;
            tw_reg       <= '0;
            k_reg        <= '0;
            drain_reg    <= DCW'(L - 1);
          end else begin
            rd_en_reg    <= 1'b1;
            rd_addr0_reg <= gen_addr0;
            rd_addr1_reg <= gen_addr1;
            tw_reg       <= gen_tw;
            k_reg        <= k_reg + LOG2N'(1);
          end
        end
        ST_DRAIN: begin
          if (drain_reg != '0) begin
            drain_reg <= drain_reg - DCW'(1);
          end else if (stage_reg == LAST_STAGE) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            state_reg    <= ST_ISSUE;
            stage_reg    <= stage_reg + SW'(1);
            rd_en_reg    <= 1'b1;
            rd_addr0_reg <= gen_addr0;
            rd_addr1_reg <= gen_addr1;
            tw_reg       <= gen_tw;
            k_reg        <= LOG2N'(1);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          stage_reg <= '0;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Write-side delay line: a read issued in cycle c reappears as a write in cycle c+L.
  logic [DLW-1:0] dly_tap [L+1];

  assign dly_tap[0] = {rd_en_reg, rd_en_reg & ~stage_reg[0], rd_addr0_reg, rd_addr1_reg};

  genvar gi;
  generate
    for (gi = 0; gi < L; gi++) begin : g_wr_dly
      logic [DLW-1:0] tap_reg;
      always_ff @(posedge clk) begin
        if (flush) tap_reg <= '0;
        else       tap_reg <= dly_tap[gi];
      end
      assign dly_tap[gi+1] = tap_reg;
    end
  endgenerate

  assign {wr_en, wr_bank, wr_addr0, wr_addr1} = dly_tap[L];

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign rd_en       = rd_en_reg;
  assign rd_bank     = stage_reg[0];
  assign rd_addr0    = rd_addr0_reg;
  assign rd_addr1    = rd_addr1_reg;
  assign tw_idx      = tw_reg;
  assign stage       = stage_reg;
  assign result_bank = RESULT_BANK;

endmodule

// File: doc/fft_bfly_scheduler.md
Name: fft_bfly_scheduler

Overview:
- Sequences an in-place radix-2 DIT FFT of N_POINTS through one shared, fully pipelined butterfly unit with fixed latency.
- Generates ping-pong sample-memory read addresses, the twiddle index, and delayed write addresses/enables. Counts stages and issues a start/done handshake.
- Sits between the sample RAM banks and the butterfly datapath. Input samples are preloaded in bit-reversed order by the upstream loader.

Parameters:
- N_POINTS, 8, FFT size; power of two, 4 to 1024.
- LOG2N, $clog2(N_POINTS), stage count and address width.
- BFLY_LATENCY, 4, cycles from butterfly inputs to butterfly outputs.
- MEM_LATENCY, 1, cycles from RAM read address to RAM read data.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  request one FFT run; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current run.
- busy  out  1  high from the first issue cycle to the last drain cycle.
- done  out  1  one-cycle pulse when the run completes.
- rd_en  out  1  read strobe for one butterfly pair.
- rd_bank  out  1  bank to read; equals stage[0].
- rd_addr0  out  LOG2N  upper-leg sample address.
- rd_addr1  out  LOG2N  lower-leg sample address.
- tw_idx  out  LOG2N-1  twiddle exponent k for W_N^k.
- wr_en  out  1  write strobe for one butterfly result pair.
- wr_bank  out  1  bank to write; equals ~stage[0] of the issuing stage.
- wr_addr0  out  LOG2N  write address for butterfly output 0.
- wr_addr1  out  LOG2N  write address for butterfly output 1.
- stage  out  $clog2(LOG2N+1)  current stage number.
- result_bank  out  1  bank holding the final result; equals LOG2N[0]; static.

Behaviour:
- Reset: FSM goes to IDLE. All outputs except result_bank are 0. Counters and the write delay line are cleared.
- All outputs are registered.
- Latency constant L = MEM_LATENCY + BFLY_LATENCY.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE with start=1: go to ISSUE; set stage=0, k=0, busy=1 next cycle.
- ISSUE: one pair per cycle, k = 0 .. N/2-1.
  - rd_en=1.
  - span = 2^stage; grp = k >> stage; pos = k & (span-1).
  - rd_addr0 = grp*2*span + pos; rd_addr1 = rd_addr0 + span.
  - tw_idx = pos << (LOG2N-1-stage).
  - After k = N/2-1, go to DRAIN with the drain counter set to L.
- DRAIN: rd_en=0 for exactly L cycles, so the final write of a stage retires before the next stage reads that bank.
  - Then, if stage < LOG2N-1: increment stage, set k=0, go to ISSUE.
  - Otherwise go to DONE.
- DONE: one cycle with done=1 and busy=0, then IDLE.
  - start is ignored in DONE.
  - Back-to-back runs therefore have DONE plus one IDLE cycle between them.
- Write path: {wr_addr0, wr_addr1, wr_bank} and wr_en reproduce the rd_* values of cycle c in cycle c+L.
  - Implemented as an L-deep shift register; no stalls.
  - wr_en is never high outside busy, except on the cycle after a run ends when L=0 (not permitted; L >= 1).
- Run length: LOG2N*(N/2 + L) busy cycles.
- start while busy: ignored, with no queuing.
- abort in any non-IDLE state: next cycle goes to IDLE.
  - busy=0, done stays 0.
  - The delay line is flushed, so no further wr_en.
- abort together with start in IDLE: abort wins; the FSM stays in IDLE.
- rst mid-run: same as abort, and all outputs are cleared.
- Address arithmetic: unsigned, LOG2N bits; it never wraps for legal k and stage.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum fft_sched_state_t;
  - functions for stage-address width;
  - the twiddle-index width helper;
  - the default BFLY_LATENCY constant, shared with the butterfly wrappers.
- One sub-module: fft_addr_gen, purely combinational.
  - Inputs: stage, k.
  - Outputs: addr0, addr1, tw_idx.
  - Lets the address formula be verified standalone.
- The delay line stays inline.

Test Plan:
1. Reset held 3 cycles, with start=1 during reset -> all outputs 0, no rd_en; after release the block stays in IDLE until start is seen.
2. N=8, L=5 run, start high at cycle 0, covering read addresses and twiddles:
   - stage0 pairs (0,1),(2,3),(4,5),(6,7), tw 0,0,0,0, rd_bank 0;
   - stage1 pairs (0,2),(1,3),(4,6),(5,7), tw 0,2,0,2, rd_bank 1;
   - stage2 pairs (0,4),(1,5),(2,6),(3,7), tw 0,1,2,3, rd_bank 0.
3. Same run, write path and handshake timing:
   - every wr_en occurs exactly 5 cycles after its rd_en, with matching addresses and wr_bank = ~rd_bank;
   - busy high for cycles 1-27; done pulses at cycle 28.
4. start held continuously high -> back-to-back runs; the second run's first rd_en appears 2 cycles after the first done, and start pulses during busy have no effect.
5. abort asserted on the 2nd ISSUE cycle of stage1 -> busy=0 and no wr_en from the next cycle, done never pulses. A fresh start then completes a normal 27-cycle run.
6. N=16, BFLY_LATENCY=1, MEM_LATENCY=1 -> 4 stages, 40 busy cycles; stage3 tw_idx sequence 0..7, result_bank 0.
